// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - state encoding and default parameters for the cpu run controller
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RUN     = 3'd2,
    HALTED  = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  localparam int unsigned DEF_RESET_CYCLES   = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_CODE_W         = 32;

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// rtl/cpu_run_ctrl_sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter
  import run_ctrl_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - reset/run/stop sequencer wrapped around the riscv core
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned CODE_W         = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              retire_valid,
  input  logic              halt_valid,
  input  logic [CODE_W-1:0] halt_code,
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic              timed_out,
  output logic [CODE_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);

  localparam logic [7:0]       HOLD_LOAD = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_t state, state_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic       start_run;
  logic       in_run;
  logic       timeout_hit;

  assign in_run      = (state == RUN);
  assign start_run   = start && ((state == IDLE) || (state == HALTED) || (state == TIMEOUT));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    case (state)
      IDLE, HALTED, TIMEOUT: begin
        if (start) begin
          state_nx = HOLD;
          hold_nx  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hold_cnt == 8'd0) begin
          state_nx = RUN;
        end else begin
          hold_nx = hold_cnt - 8'd1;
        end
      end
      RUN: begin
        // halt takes priority over a timeout landing in the same cycle
        if (halt_valid) begin
          state_nx = HALTED;
        end else if (timeout_hit) begin
          state_nx = TIMEOUT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // status outputs are flopped from the next state so they switch with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold_cnt  <= 8'd0;
      cpu_rst   <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      cpu_rst   <= (state_nx != RUN);
      running   <= (state_nx == RUN);
      done      <= (state_nx == HALTED) || (state_nx == TIMEOUT);
      timed_out <= (state_nx == TIMEOUT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exit_code <= '0;
    end else if (start_run) begin
      exit_code <= '0;
    end else if (in_run && halt_valid) begin
      exit_code <= halt_code;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_run),
    .inc   (in_run),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_run),
    .inc   (in_run && retire_valid),
    .q     (instret_count)
  );

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller for the riscv core. It replaces the hand-written reset pulse and fixed-length run with a parametrised sequencer.
- Holds the core in reset for a programmable number of cycles after start.
- Runs the core while counting cycles and retired instructions.
- Stops on a halt request from the core (ebreak/ecall exit) or on a cycle timeout, and latches the exit code.
- Sits between the top-level clk/reset and the cpu instance; benches and the FPGA top both use it.

Parameters:
RESET_CYCLES, 2, cycles cpu_rst is held high after start (legal range 1..255)
TIMEOUT_CYCLES, 1000, run cycles before forced timeout; 0 disables timeout
CNT_W, 32, width of cycle and instret counters
CODE_W, 32, width of exit code

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a run from IDLE, HALTED or TIMEOUT
retire_valid  input  1  core retired one instruction this cycle
halt_valid  input  1  core requests stop this cycle
halt_code  input  CODE_W  exit code, valid with halt_valid
cpu_rst  output  1  active-high synchronous reset to core
running  output  1  high while in RUN
done  output  1  high in HALTED or TIMEOUT
timed_out  output  1  high in TIMEOUT
exit_code  output  CODE_W  code latched at halt
cycle_count  output  CNT_W  RUN cycles of the current or last run
instret_count  output  CNT_W  retired instructions of the current or last run

Behaviour:
- Async reset (reset=0) forces the following immediately:
  - state=IDLE, cpu_rst=1, running=0, done=0, timed_out=0;
  - exit_code=0, cycle_count=0, instret_count=0, hold counter=0.
- All outputs are registered; each is a decode of state or a register.
- States: IDLE, HOLD, RUN, HALTED, TIMEOUT.
- IDLE: cpu_rst=1. On start, go to HOLD, load hold counter with RESET_CYCLES-1, and clear both counters, exit_code and timed_out.
- HOLD: cpu_rst=1. Decrement the hold counter each cycle; go to RUN in the cycle it reads 0. cpu_rst is therefore high for exactly RESET_CYCLES cycles after the start edge.
- RUN: cpu_rst=0, running=1.
  - cycle_count increments every cycle.
  - instret_count increments on retire_valid, including the cycle in which halt_valid is sampled.
  - halt_valid: go to HALTED and latch exit_code<=halt_code.
  - TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 with no halt_valid: go to TIMEOUT; exit_code stays 0.
  - halt_valid and timeout in the same cycle: HALTED wins; timed_out=0.
- HALTED/TIMEOUT: cpu_rst=1 (core frozen), done=1; timed_out=1 only in TIMEOUT. Counters and exit_code are held. start restarts as from IDLE.
- start while in HOLD or RUN: ignored.
- retire_valid and halt_valid outside RUN: ignored.
- Counters saturate at all-ones and never wrap.
- Reset mid-run: async return to IDLE; nothing is preserved.
- Final cycle_count on timeout equals TIMEOUT_CYCLES. On halt it equals the number of RUN cycles including the halt cycle.

Decomposition:
- Package run_ctrl_pkg:
  - state enum encoding (IDLE=0, HOLD=1, RUN=2, HALTED=3, TIMEOUT=4; 3-bit);
  - default parameter constants.
- One natural sub-module: sat_counter (parameter W; inputs clk, reset, clr, inc; output q; saturating). Instantiated twice, for cycle and instret.
- FSM and hold counter stay in cpu_run_ctrl.

Test Plan:
- Reset then start, RESET_CYCLES=2 -> cpu_rst high exactly 2 cycles after the start edge, then running=1 on the next edge.
- RUN with retire_valid every other cycle; halt_valid with halt_code=0x0000002A at run cycle 10 -> done=1, exit_code=0x2A, cycle_count=10, instret_count=5, cpu_rst=1.
- TIMEOUT_CYCLES=20, no halt -> timed_out=1, done=1, cycle_count=20, exit_code=0.
- halt_valid=1 with code 7 at run cycle 20 with TIMEOUT_CYCLES=20 -> HALTED, timed_out=0, exit_code=7.
- reset=0 pulsed at run cycle 5 -> all outputs at reset values immediately; start pulse mid-RUN -> no effect; start after HALTED -> counters clear and a new HOLD begins.
- CNT_W=4, TIMEOUT_CYCLES=0, 20 retire cycles then halt -> cycle_count=15, instret_count=15 (saturated).
